// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the RV32I execute stage and memory_bank.
// One request per handshake; error, store or load access, then a held response.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  input  logic [4:0]  i_req_rd,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic [4:0]  o_rsp_rd,
  output logic        o_rsp_err,
  output logic        o_mem_read_en,
  output logic        o_mem_write_en,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic [2:0]  o_mem_funct3,
  input  logic [31:0] i_mem_read_data
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e          r_state, w_state_d;
  logic            r_we, w_we_d;
  logic [31:0]     r_addr, w_addr_d;
  logic [31:0]     r_wdata, w_wdata_d;
  logic [2:0]      r_funct3, w_funct3_d;
  logic [4:0]      r_rd, w_rd_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [31:0]     r_rdata, w_rdata_d;
  logic            r_err, w_err_d;
  logic            r_rd_en, w_rd_en_d;
  logic            r_wr_en, w_wr_en_d;

  logic            w_accept;
  logic            w_legal;
  logic            w_aligned;

  assign w_accept = (r_state == StIdle) && i_req_valid;

  always_comb begin
    w_legal = 1'b0;
    if (i_req_we) begin
      w_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                (i_req_funct3 == 3'b010);
    end else begin
      w_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                (i_req_funct3 == 3'b101);
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    if (i_req_funct3[1:0] == 2'b01) begin
      w_aligned = (i_req_addr[0] == 1'b0);
    end else if (i_req_funct3[1:0] == 2'b10) begin
      w_aligned = (i_req_addr[1:0] == 2'b00);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_we_d     = r_we;
    w_addr_d   = r_addr;
    w_wdata_d  = r_wdata;
    w_funct3_d = r_funct3;
    w_rd_d     = r_rd;
    w_cnt_d    = r_cnt;
    w_rdata_d  = r_rdata;
    w_err_d    = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_we_d     = i_req_we;
          w_addr_d   = i_req_addr;
          w_wdata_d  = i_req_wdata;
          w_funct3_d = i_req_funct3;
          w_rd_d     = i_req_rd;
          w_cnt_d    = '0;
          w_rdata_d  = '0;
          // Rejected requests skip memory entirely and answer next cycle.
          if (!w_legal || !w_aligned) begin
            w_err_d   = 1'b1;
            w_state_d = StResp;
          end else begin
            w_err_d   = 1'b0;
            w_state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (r_we) begin
          w_state_d = StResp;
        end else if (r_cnt == CntLast) begin
          w_rdata_d = i_mem_read_data;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResp: begin
        if (i_rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Enables are registered copies of the next state so they align with ACCESS.
  assign w_rd_en_d = (w_state_d == StAccess) && !w_we_d;
  assign w_wr_en_d = (w_state_d == StAccess) && w_we_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_rd_en  <= 1'b0;
      r_wr_en  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_we     <= w_we_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_funct3 <= w_funct3_d;
      r_rd     <= w_rd_d;
      r_cnt    <= w_cnt_d;
      r_rdata  <= w_rdata_d;
      r_err    <= w_err_d;
      r_rd_en  <= w_rd_en_d;
      r_wr_en  <= w_wr_en_d;
    end
  end

  assign o_req_ready      = (r_state == StIdle);
  assign o_rsp_valid      = (r_state == StResp);
  assign o_rsp_rdata      = r_rdata;
  assign o_rsp_rd         = r_rd;
  assign o_rsp_err        = r_err;
  assign o_mem_read_en    = r_rd_en;
  assign o_mem_write_en   = r_wr_en;
  assign o_mem_address    = r_addr;
  assign o_mem_write_data = r_wdata;
  assign o_mem_funct3     = r_funct3;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a small behavioural memory_bank model.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic [4:0]  req_rd;

  logic        a_req_valid, a_rsp_ready, b_req_valid, b_rsp_ready;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_re, a_we;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_re, b_we;
  logic [31:0] a_rsp_rdata, a_addr, a_wdata, a_rdata;
  logic [31:0] b_rsp_rdata, b_addr, b_wdata, b_rdata;
  logic [4:0]  a_rsp_rd, b_rsp_rd;
  logic [2:0]  a_f3, b_f3;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign a_rsp_ready = rsp_ready & ~sel;
  assign b_rsp_ready = rsp_ready & sel;

  lsu_mem_ctrl #(.MEM_LAT(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_funct3(req_f3), .i_req_rd(req_rd), .o_rsp_valid(a_rsp_valid),
    .i_rsp_ready(a_rsp_ready), .o_rsp_rdata(a_rsp_rdata), .o_rsp_rd(a_rsp_rd),
    .o_rsp_err(a_rsp_err), .o_mem_read_en(a_re), .o_mem_write_en(a_we),
    .o_mem_address(a_addr), .o_mem_write_data(a_wdata), .o_mem_funct3(a_f3),
    .i_mem_read_data(a_rdata)
  );

  lsu_mem_ctrl #(.MEM_LAT(3)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_funct3(req_f3), .i_req_rd(req_rd), .o_rsp_valid(b_rsp_valid),
    .i_rsp_ready(b_rsp_ready), .o_rsp_rdata(b_rsp_rdata), .o_rsp_rd(b_rsp_rd),
    .o_rsp_err(b_rsp_err), .o_mem_read_en(b_re), .o_mem_write_en(b_we),
    .o_mem_address(b_addr), .o_mem_write_data(b_wdata), .o_mem_funct3(b_f3),
    .i_mem_read_data(b_rdata)
  );

  function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] o,
                                         input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [1:0] o,
                                         input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r;
    r = old;
    case (f)
      3'b000:  r[{o, 3'b000} +: 8] = d[7:0];
      3'b001:  r[{o[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] a_mem [16];
  logic [31:0] b_mem [16];
  assign a_rdata = rd_ext(a_mem[a_addr[5:2]], a_addr[1:0], a_f3);
  assign b_rdata = rd_ext(b_mem[b_addr[5:2]], b_addr[1:0], b_f3);

  int a_re_n = 0, a_we_n = 0, b_re_n = 0, b_we_n = 0;
  always @(posedge clk) begin
    if (a_we) a_mem[a_addr[5:2]] <= wmerge(a_mem[a_addr[5:2]], a_addr[1:0], a_wdata, a_f3);
    if (b_we) b_mem[b_addr[5:2]] <= wmerge(b_mem[b_addr[5:2]], b_addr[1:0], b_wdata, b_f3);
    if (a_re) a_re_n <= a_re_n + 1;
    if (a_we) a_we_n <= a_we_n + 1;
    if (b_re) b_re_n <= b_re_n + 1;
    if (b_we) b_we_n <= b_we_n + 1;
  end

  logic        s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata;
  logic [4:0]  s_rsp_rd;
  int          s_re_n, s_we_n;
  assign s_req_ready = sel ? b_req_ready : a_req_ready;
  assign s_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign s_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign s_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign s_rsp_rd    = sel ? b_rsp_rd    : a_rsp_rd;
  assign s_re_n      = sel ? b_re_n      : a_re_n;
  assign s_we_n      = sel ? b_we_n      : a_we_n;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; report accept->rsp_valid latency and enable-cycle counts.
  task automatic req(input logic s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rd,
                     output int lat, output int re_n, output int we_n);
    int re0, we0;
    @(negedge clk);
    sel = s;
    #1;
    re0 = s_re_n;
    we0 = s_we_n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_f3 = f3; req_rd = rd;
    req_valid = 1'b1;
    check("req_ready_idle", s_req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!s_rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    re_n = s_re_n - re0;
    we_n = s_we_n - we0;
  endtask

  // Check the response, hold rsp_ready low for 'hold' cycles, then accept it.
  task automatic ack(input int hold, input logic [31:0] rdata, input logic [4:0] rd,
                     input logic err);
    check("rsp_rdata", s_rsp_rdata, rdata);
    check("rsp_rd", s_rsp_rd, rd);
    check("rsp_err", s_rsp_err, err);
    check("rsp_req_ready_low", s_req_ready, 1'b0);
    repeat (hold) begin
      @(negedge clk);
      check("held_valid", s_rsp_valid, 1'b1);
      check("held_rdata", s_rsp_rdata, rdata);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("back_idle_ready", s_req_ready, 1'b1);
    check("rsp_valid_drop", s_rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat, re_n, we_n;

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_f3 = '0; req_rd = '0;
    #1;
    check("rst_req_ready", a_req_ready, 1'b1);
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    check("rst_rsp_err", a_rsp_err, 1'b0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst_rsp_rd", a_rsp_rd, 5'd0);
    check("rst_read_en", a_re, 1'b0);
    check("rst_write_en", a_we, 1'b0);
    check("rst_address", a_addr, 32'h0);
    check("rst_write_data", a_wdata, 32'h0);
    check("rst_funct3", a_f3, 3'b000);
    check("rst_b_read_en", b_re, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // SW 0x4
    req(1'b0, 1'b1, 32'h4, 32'h11223344, 3'b010, 5'd3, lat, re_n, we_n);
    check("sw_lat", lat, 2); check("sw_we_cycles", we_n, 1); check("sw_re_cycles", re_n, 0);
    ack(0, 32'h0, 5'd3, 1'b0);
    // LW 0x4
    req(1'b0, 1'b0, 32'h4, 32'h0, 3'b010, 5'd5, lat, re_n, we_n);
    check("lw_lat", lat, 2); check("lw_re_cycles", re_n, 1); check("lw_we_cycles", we_n, 0);
    ack(0, 32'h11223344, 5'd5, 1'b0);
    // SB 0x5 then LW / LB / LBU / LH
    req(1'b0, 1'b1, 32'h5, 32'h000000AA, 3'b000, 5'd0, lat, re_n, we_n);
    check("sb_lat", lat, 2); check("sb_we_cycles", we_n, 1);
    ack(0, 32'h0, 5'd0, 1'b0);
    req(1'b0, 1'b0, 32'h4, 32'h0, 3'b010, 5'd6, lat, re_n, we_n);
    ack(0, 32'h1122AA44, 5'd6, 1'b0);
    req(1'b0, 1'b0, 32'h5, 32'h0, 3'b000, 5'd7, lat, re_n, we_n);
    ack(0, 32'hFFFFFFAA, 5'd7, 1'b0);
    req(1'b0, 1'b0, 32'h5, 32'h0, 3'b100, 5'd8, lat, re_n, we_n);
    ack(0, 32'h000000AA, 5'd8, 1'b0);
    req(1'b0, 1'b0, 32'h6, 32'h0, 3'b001, 5'd11, lat, re_n, we_n);
    check("lh_lat", lat, 2);
    ack(0, 32'h00001122, 5'd11, 1'b0);

    // Errors: misaligned LW, misaligned SH, illegal load f3, illegal store f3
    req(1'b0, 1'b0, 32'h6, 32'h0, 3'b010, 5'd9, lat, re_n, we_n);
    check("mis_lw_lat", lat, 1); check("mis_lw_re", re_n, 0); check("mis_lw_we", we_n, 0);
    ack(0, 32'h0, 5'd9, 1'b1);
    req(1'b0, 1'b1, 32'h5, 32'h1234, 3'b001, 5'd12, lat, re_n, we_n);
    check("mis_sh_lat", lat, 1); check("mis_sh_we", we_n, 0);
    ack(0, 32'h0, 5'd12, 1'b1);
    req(1'b0, 1'b0, 32'h0, 32'h0, 3'b011, 5'd13, lat, re_n, we_n);
    check("ill_ld_lat", lat, 1); check("ill_ld_re", re_n, 0);
    ack(0, 32'h0, 5'd13, 1'b1);
    req(1'b0, 1'b1, 32'h0, 32'h55, 3'b100, 5'd14, lat, re_n, we_n);
    check("ill_st_lat", lat, 1); check("ill_st_we", we_n, 0);
    ack(0, 32'h0, 5'd14, 1'b1);
    req(1'b0, 1'b0, 32'h4, 32'h0, 3'b010, 5'd15, lat, re_n, we_n);
    ack(0, 32'h1122AA44, 5'd15, 1'b0);

    // MEM_LAT=3 instance: store then load with a stalled response
    req(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 3'b010, 5'd1, lat, re_n, we_n);
    check("b_sw_lat", lat, 2); check("b_sw_we", we_n, 1);
    ack(0, 32'h0, 5'd1, 1'b0);
    req(1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 5'd10, lat, re_n, we_n);
    check("b_lw_lat", lat, 4); check("b_lw_re_cycles", re_n, 3);
    ack(4, 32'hCAFEF00D, 5'd10, 1'b0);

    // Reset in the middle of a MEM_LAT=3 load
    @(negedge clk);
    sel = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_f3 = 3'b010; req_rd = 5'd2;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_access_re", b_re, 1'b1);
    check("mid_access_addr", b_addr, 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_re", b_re, 1'b0);
    check("rst_async_we", b_we, 1'b0);
    check("rst_async_ready", b_req_ready, 1'b1);
    check("rst_async_valid", b_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_no_rsp", b_rsp_valid, 1'b0);
    check("post_rst_ready", b_req_ready, 1'b1);
    req(1'b0, 1'b0, 32'h4, 32'h0, 3'b010, 5'd4, lat, re_n, we_n);
    check("post_rst_lw_lat", lat, 2);
    ack(0, 32'h1122AA44, 5'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
